// File: rtl/psw_cmp_ctrl.sv
// Password compare sequencer: sweeps entered digits against stored and master
// passwords one digit per cycle, producing verdicts and a failed-attempt count.
module psw_cmp_ctrl #(
    parameter int MAX_LEN  = 8,
    parameter int DIGIT_W  = 4,
    parameter int LOCK_THR = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [3:0]         mem_len,
    input  logic [3:0]         buff_len,
    input  logic [3:0]         master_len,
    output logic [2:0]         rd_addr,
    input  logic [DIGIT_W-1:0] mem_digit,
    input  logic [DIGIT_W-1:0] buff_digit,
    input  logic [DIGIT_W-1:0] master_digit,
    input  logic               clr_err,
    output logic               busy,
    output logic               done,
    output logic               same,
    output logic               master_same,
    output logic [3:0]         error_num,
    output logic               lockout
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [3:0] MAX_L = 4'(MAX_LEN);
    localparam logic [4:0] THR   = 5'(LOCK_THR);

    function automatic logic [3:0] clamp(input logic [3:0] l);
        return (l > MAX_L) ? MAX_L : l;
    endfunction

    state_t     state;
    state_t     state_nx;
    logic [2:0] idx;
    logic [3:0] blen_q;
    logic       mode_q;
    logic       m_ok;
    logic       k_ok;

    logic [3:0] buff_c;
    logic [3:0] mem_c;
    logic [3:0] master_c;
    logic       last_addr;
    logic       m_hit;
    logic       k_hit;

    assign buff_c    = clamp(buff_len);
    assign mem_c     = clamp(mem_len);
    assign master_c  = clamp(master_len);
    assign last_addr = ({1'b0, idx} == (blen_q - 4'd1));
    assign m_hit     = (buff_digit == mem_digit);
    assign k_hit     = (buff_digit == master_digit);
    assign lockout   = ({1'b0, error_num} >= THR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (buff_c == 4'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_addr) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        rd_addr = (state == RUN) ? idx : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            blen_q      <= '0;
            mode_q      <= 1'b0;
            m_ok        <= 1'b0;
            k_ok        <= 1'b0;
            same        <= 1'b0;
            master_same <= 1'b0;
            error_num   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode_q      <= mode;
                        blen_q      <= buff_c;
                        idx         <= '0;
                        same        <= 1'b0;
                        master_same <= 1'b0;
                        // An empty entry never matches anything
                        if (buff_c == 4'd0) begin
                            m_ok <= 1'b0;
                            k_ok <= 1'b0;
                        end else begin
                            m_ok <= (buff_c == mem_c);
                            k_ok <= mode & (buff_c == master_c);
                        end
                    end
                end
                RUN: begin
                    if (idx != 3'd0) begin
                        m_ok <= m_ok & m_hit;
                        k_ok <= k_ok & k_hit;
                    end
                    idx <= idx + 3'd1;
                end
                DRAIN: begin
                    m_ok <= m_ok & m_hit;
                    k_ok <= k_ok & k_hit;
                end
                DONE: begin
                    same        <= m_ok;
                    master_same <= k_ok;
                    // Once locked out, only the master password resets the count
                    if (mode_q) begin
                        if (k_ok) begin
                            error_num <= '0;
                        end else if (m_ok && ({1'b0, error_num} < THR)) begin
                            error_num <= '0;
                        end else if (error_num != 4'hf) begin
                            error_num <= error_num + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
            if (clr_err) begin
                error_num <= '0;
            end
        end
    end

endmodule

// File: tb/tb_psw_cmp_ctrl.sv
// Directed bench for psw_cmp_ctrl: vector table of compare transactions plus
// hand sequences for ignored start and reset mid-sweep.
module tb_psw_cmp_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [3:0] mem_len;
    logic [3:0] buff_len;
    logic [3:0] master_len;
    logic [2:0] rd_addr;
    logic [3:0] mem_digit;
    logic [3:0] buff_digit;
    logic [3:0] master_digit;
    logic       clr_err;
    logic       busy;
    logic       done;
    logic       same;
    logic       master_same;
    logic [3:0] error_num;
    logic       lockout;

    logic [31:0] mem_w;
    logic [31:0] buff_w;
    logic [31:0] master_w;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    psw_cmp_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .mem_len     (mem_len),
        .buff_len    (buff_len),
        .master_len  (master_len),
        .rd_addr     (rd_addr),
        .mem_digit   (mem_digit),
        .buff_digit  (buff_digit),
        .master_digit(master_digit),
        .clr_err     (clr_err),
        .busy        (busy),
        .done        (done),
        .same        (same),
        .master_same (master_same),
        .error_num   (error_num),
        .lockout     (lockout)
    );

    // Synchronous-read storage, one cycle latency
    always @(posedge clk) begin
        mem_digit    <= mem_w[{rd_addr, 2'b00} +: 4];
        buff_digit   <= buff_w[{rd_addr, 2'b00} +: 4];
        master_digit <= master_w[{rd_addr, 2'b00} +: 4];
    end

    typedef struct {
        logic        mode;
        logic [3:0]  ml;
        logic [3:0]  bl;
        logic [3:0]  kl;
        logic [31:0] mw;
        logic [31:0] bw;
        logic [31:0] kw;
        logic        clr;
        int          lat;
        logic        es;
        logic        ems;
        logic [3:0]  eerr;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] PW   = 32'h0000_4321;
    localparam logic [31:0] BAD  = 32'h0000_5321;
    localparam logic [31:0] MST  = 32'h0005_6789;
    localparam logic [31:0] MOFF = 32'h0005_6788;
    localparam logic [31:0] PW8  = 32'h8765_4321;

    function automatic vec_t mk(input logic md, input logic [3:0] ml,
                                input logic [3:0] bl, input logic [31:0] mw,
                                input logic [31:0] bw, input logic clr,
                                input int lat, input logic es,
                                input logic ems, input logic [3:0] eerr);
        vec_t v;
        v.mode = md;
        v.ml   = ml;
        v.bl   = bl;
        v.kl   = 4'd5;
        v.mw   = mw;
        v.bw   = bw;
        v.kw   = MST;
        v.clr  = clr;
        v.lat  = lat;
        v.es   = es;
        v.ems  = ems;
        v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int id);
        int lat;
        int bad;
        @(negedge clk);
        mem_w      = v.mw;
        buff_w     = v.bw;
        master_w   = v.kw;
        mode       = v.mode;
        mem_len    = v.ml;
        buff_len   = v.bl;
        master_len = v.kl;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k <= v.lat - 2 && rd_addr !== 3'(k - 1)) bad++;
            if (busy !== 1'b1) bad++;
            if (done === 1'b1) begin
                lat = k;
                clr_err = v.clr;
                break;
            end
        end
        chk($sformatf("v%0d latency", id), lat, v.lat);
        chk($sformatf("v%0d addr/busy", id), bad, 0);
        @(negedge clk);
        clr_err = 1'b0;
        chk($sformatf("v%0d same", id), same, v.es);
        chk($sformatf("v%0d master_same", id), master_same, v.ems);
        chk($sformatf("v%0d error_num", id), error_num, v.eerr);
        chk($sformatf("v%0d lockout", id), lockout, (v.eerr >= 10));
        chk($sformatf("v%0d idle", id), {busy, done}, 0);
    endtask

    initial begin
        int e;
        int nd;
        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        mem_len = 4'd0;
        buff_len = 4'd0;
        master_len = 4'd0;
        clr_err = 1'b0;
        mem_w = '0;
        buff_w = '0;
        master_w = '0;

        vecs.push_back(mk(0, 4, 4, PW, PW, 0, 6, 1, 0, 0));
        vecs.push_back(mk(0, 4, 4, PW, BAD, 0, 6, 0, 0, 0));
        vecs.push_back(mk(0, 4, 3, PW, PW, 0, 5, 0, 0, 0));
        vecs.push_back(mk(1, 4, 5, PW, MOFF, 0, 7, 0, 0, 1));
        for (int i = 2; i <= 10; i++)
            vecs.push_back(mk(1, 4, 4, PW, BAD, 0, 6, 0, 0, 4'(i)));
        vecs.push_back(mk(1, 4, 4, PW, PW, 0, 6, 1, 0, 11));
        vecs.push_back(mk(1, 4, 5, PW, MST, 0, 7, 0, 1, 0));
        e = 0;
        for (int i = 0; i < 20; i++) begin
            e = (e == 15) ? 15 : e + 1;
            vecs.push_back(mk(1, 4, 4, PW, BAD, 0, 6, 0, 0, 4'(e)));
        end
        vecs.push_back(mk(1, 4, 4, PW, BAD, 1, 6, 0, 0, 0));
        vecs.push_back(mk(1, 4, 4, PW, BAD, 0, 6, 0, 0, 1));
        vecs.push_back(mk(1, 4, 4, PW, PW, 0, 6, 1, 0, 0));
        vecs.push_back(mk(0, 4, 0, PW, PW, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 9, 12, PW8, PW8, 0, 10, 1, 0, 0));
        vecs.push_back(mk(1, 4, 4, PW, BAD, 0, 6, 0, 0, 1));

        repeat (2) @(negedge clk);
        chk("reset outputs",
            {busy, done, same, master_same, error_num, lockout, rd_addr}, 0);
        rst = 1'b0;

        foreach (vecs[i]) run(vecs[i], i);

        // start pulsed while busy must be dropped
        @(negedge clk);
        mem_w = PW; buff_w = PW; mode = 1'b0;
        mem_len = 4'd4; buff_len = 4'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nd = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 2) start = 1'b1;
            else start = 1'b0;
            if (done === 1'b1) nd++;
        end
        chk("busy start dones", nd, 1);
        chk("busy start idle", busy, 0);
        chk("busy start err", error_num, 1);

        // Reset in the middle of RUN aborts cleanly
        @(negedge clk);
        mode = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid reset outputs",
            {busy, done, same, master_same, error_num, lockout, rd_addr}, 0);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        chk("mid reset quiet", nd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/psw_cmp_ctrl.md
# psw_cmp_ctrl

Sequencer that compares the entered-digit buffer against the stored password memory and the master password ROM, one digit per cycle. It produces the `same` / `master_same` verdicts and the `error_num` failed-attempt count that the lock control FSM consumes. It sits between the control FSM (start/mode/done handshake) and the digit storage, which has synchronous-read memories sharing one read address.

## Interface
- `MAX_LEN`, default 8: maximum password length in digits; lengths above it are clamped.
- `DIGIT_W`, default 4: width of one digit.
- `LOCK_THR`, default 10: failed-attempt count at which `lockout` asserts.

Ports:
- `clk`  in  1: the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin one comparison; sampled only in IDLE.
- `mode`  in  1: 0 = confirm (buffer vs memory only), 1 = challenge (also master compare and error counting).
- `mem_len`  in  4: stored password length.
- `buff_len`  in  4: entered password length.
- `master_len`  in  4: master password length.
- `rd_addr`  out  3: digit index driven to the memory, buffer and ROM.
- `mem_digit`  in  DIGIT_W: memory data, valid the cycle after `rd_addr`.
- `buff_digit`  in  DIGIT_W: buffer data, same latency.
- `master_digit`  in  DIGIT_W: ROM data, same latency.
- `clr_err`  in  1: clears `error_num`.
- `busy`  out  1: comparison in progress.
- `done`  out  1: one-cycle pulse when the verdicts are final.
- `same`  out  1: entry equals the stored password.
- `master_same`  out  1: entry equals the master password (challenge mode only).
- `error_num`  out  4: failed challenge count.
- `lockout`  out  1: `error_num >= LOCK_THR`.

## Operation
States: IDLE, RUN, DRAIN, DONE.

IDLE:
- `busy` = 0.
- On `start`: latch `mode` and the lengths, clamping each to `MAX_LEN`.
- Clear `same` and `master_same`.
- Set the running flags: `m_ok = (buff_len == mem_len)`; `k_ok = mode & (buff_len == master_len)`.
- Set `idx` = 0.
- If `buff_len` == 0, go to DONE with both flags forced to 0. Otherwise go to RUN.

RUN:
- `rd_addr` = `idx`.
- If `idx` > 0, compare the returned data for `idx-1`: `m_ok &= (buff_digit == mem_digit)`, `k_ok &= (buff_digit == master_digit)`.
- `idx` increments.
- When `idx` reaches `buff_len-1` (after issuing that address), go to DRAIN.

DRAIN:
- Compare the last returned digit.
- Go to DONE.

DONE:
- `done` = 1 for this cycle.
- `same` ← `m_ok`; `master_same` ← `k_ok`. Both are held until the next accepted `start`.
- In challenge mode, update `error_num`:
  - If `master_same`: set to 0.
  - Else if `same` and `error_num < LOCK_THR`: set to 0.
  - Otherwise: increment, saturating at 15.
- Confirm mode never touches `error_num`.
- Next state is always IDLE.

Priorities and boundary conditions:
- `start` while `busy`: ignored, no queuing.
- `clr_err` has priority over the DONE update in the same cycle; result is 0.
- When `lockout` is high, `same` alone does not clear the count; only `master_same` or `clr_err` does. The verdict `same` is still reported.
- Length mismatch still runs the full digit sweep, so timing is independent of the result.
- Length clamping: a length > `MAX_LEN` is treated as `MAX_LEN`.
- Reset at any point returns to IDLE and aborts any comparison in flight with no `done`.

## Timing
- Reset values: `busy` = 0, `done` = 0, `same` = 0, `master_same` = 0, `error_num` = 0, `lockout` = 0, `rd_addr` = 0.
- `start` sampled at edge T with `buff_len` = N ≥ 1:
  - RUN occupies cycles T+1 .. T+N, with `rd_addr` = 0 .. N-1.
  - DRAIN occupies cycle T+N+1.
  - DONE occupies cycle T+N+2.
  - `same` and `master_same` are valid from T+N+3 (registered at the DONE edge).
- `busy` is high in cycles T+1 .. T+N+2.
- `done` is high in cycle T+N+2 only; `error_num` updates at the same edge.
- `buff_len` = 0: DONE at T+1, verdicts 0.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after DONE, i.e. minimum period N+3.
- `lockout` is combinational from `error_num`.

## Test plan
- Confirm match: mem = buff = 1,2,3,4, lengths 4, `mode` = 0, start at T → `rd_addr` 0..3 in T+1..T+4, `done` at T+6, `same` = 1, `master_same` = 0, `error_num` unchanged.
- Mismatch and length mismatch: buff = 1,2,3,5 → `same` = 0. Separately, buff = 1,2,3 with `mem_len` = 4 → `same` = 0, `done` at T+5.
- Challenge failures: 10 wrong entries in `mode` = 1 → `error_num` = 10 and `lockout` = 1. An 11th entry with the correct password → `same` = 1 but `error_num` = 11. A master match → `error_num` = 0.
- Saturation and clear: 20 failures → `error_num` = 15. `clr_err` pulsed in the same cycle as a failing DONE → `error_num` = 0.
- Protocol:
  - `start` pulsed during `busy` → ignored, one `done` only.
  - `buff_len` = 0 → `done` at T+1, both verdicts 0.
  - `buff_len` = 12 → clamped to 8 digits.
- Reset mid-RUN (cycle T+2) → next cycle `busy` = 0, no `done`, outputs back to reset values, `error_num` = 0.
